// File: rtl/float_acc_ctrl.sv
// Streaming fp32 accumulator sequencer in front of a fixed-latency pipelined adder.
// Feeds operands and recirculated partial sums into the adder, then pair-reduces them.
module float_acc_ctrl #(
    parameter int unsigned LAT = 5
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic [31:0] add_A,
    output logic [31:0] add_B,
    input  logic [31:0] add_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {StAccum, StReduce, StDone} state_e;

    state_e      state_q, state_d;
    logic [LAT:0] vld_q, vld_d;
    logic [31:0] h_q, h_d;
    logic        h_v_q, h_v_d;
    logic [31:0] add_a_d, add_b_d;
    logic [31:0] out_data_d;
    logic        out_valid_d;
    logic        issue;
    logic        ret;
    logic        accept;

    assign ret      = vld_q[LAT];
    assign in_ready = (state_q == StAccum);
    assign accept   = in_valid & in_ready;
    assign busy     = (state_q != StAccum) | (|vld_q);
    assign vld_d    = {vld_q[LAT-1:0], issue};

    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        add_a_d     = 32'h0;
        add_b_d     = 32'h0;
        h_d         = h_q;
        h_v_d       = h_v_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;

        unique case (state_q)
            StAccum: begin
                // A returning partial sum must be consumed this cycle, either
                // folded into the new operand or recirculated alone.
                if (accept) begin
                    issue   = 1'b1;
                    add_a_d = in_data;
                    add_b_d = ret ? add_result : 32'h0;
                    if (in_last) begin
                        state_d = StReduce;
                        h_v_d   = 1'b0;
                    end
                end else if (ret) begin
                    issue   = 1'b1;
                    add_a_d = add_result;
                end
            end
            StReduce: begin
                if (ret) begin
                    if (h_v_q) begin
                        issue   = 1'b1;
                        add_a_d = h_q;
                        add_b_d = add_result;
                        h_v_d   = 1'b0;
                    end else if (vld_q[LAT-1:0] == '0) begin
                        out_data_d  = add_result;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        h_d   = add_result;
                        h_v_d = 1'b1;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StAccum;
                end
            end
            default: begin
                state_d = StAccum;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= StAccum;
            vld_q     <= '0;
            h_q       <= 32'h0;
            h_v_q     <= 1'b0;
            add_A     <= 32'h0;
            add_B     <= 32'h0;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
        end else begin
            state_q   <= state_d;
            vld_q     <= vld_d;
            h_q       <= h_d;
            h_v_q     <= h_v_d;
            add_A     <= add_a_d;
            add_B     <= add_b_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_float_acc_ctrl.sv
// Directed bench for float_acc_ctrl with a behavioural LAT-deep fp32 adder model.
module tb_float_acc_ctrl;

    localparam int unsigned LAT = 5;

    logic        CLK;
    logic        RESETn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] add_A;
    logic [31:0] add_B;
    logic [31:0] add_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_hs     = 0;
    int max_live = 0;
    bit tracking = 1'b0;

    float_acc_ctrl #(.LAT(LAT)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .add_A      (add_A),
        .add_B      (add_B),
        .add_result (add_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Normal numbers only; every sum used here is exactly representable.
    function automatic real to_real(input logic [31:0] x);
        logic [10:0] e;
        logic [63:0] b;
        if (x[30:23] == 8'h0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        b = {x[31], e, x[22:0], 29'h0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] from_real(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        if (b[62:52] == 11'h0) return {b[63], 31'h0};
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    // Adder model: not reset, preloaded with junk so stale results are visible.
    logic [31:0] pipe [LAT];
    initial for (int i = 0; i < LAT; i++) pipe[i] = 32'h40400000;
    always @(posedge CLK) begin
        pipe[0] <= from_real(to_real(add_A) + to_real(add_B));
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign add_result = pipe[LAT-1];

    always @(posedge CLK) if (out_valid && out_ready) n_hs <= n_hs + 1;

    always @(negedge CLK) begin
        if (tracking && ($countones(dut.vld_q) + int'(dut.h_v_q)) > max_live)
            max_live <= $countones(dut.vld_q) + int'(dut.h_v_q);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 100) begin
            tick(1);
            n++;
        end
        tick(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'h0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            tick(1);
            cyc++;
        end
        check("out_valid_seen", {31'h0, out_valid}, 32'h1);
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    int cyc;
    int hs0;

    initial begin
        RESETn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick(2);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_add_A", add_A, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        RESETn = 1'b1;
        tick(1);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Single element: sum after LAT+2 cycles counting the acceptance cycle.
        send(32'h3F800000, 1'b1);
        wait_out(cyc);
        check("single_latency", cyc + 1, LAT + 2);
        check("single_data", out_data, 32'h3F800000);
        check("single_in_ready", {31'h0, in_ready}, 32'h0);
        take_out();
        check("single_in_ready_after", {31'h0, in_ready}, 32'h1);

        // Four back-to-back ones, exactly one output pulse.
        hs0 = n_hs;
        for (int i = 0; i < 4; i++) send(32'h3F800000, i == 3);
        wait_out(cyc);
        check("four_data", out_data, 32'h40800000);
        take_out();
        check("four_valid_drop", {31'h0, out_valid}, 32'h0);
        check("four_busy_drop", {31'h0, busy}, 32'h0);
        tick(3 * LAT);
        check("four_one_pulse", n_hs - hs0, 1);

        // Ten ones: more elements than pipeline slots.
        tracking = 1'b1;
        for (int i = 0; i < 10; i++) send(32'h3F800000, i == 9);
        wait_out(cyc);
        tracking = 1'b0;
        check("ten_data", out_data, 32'h41200000);
        check("ten_live_max_ok", {31'h0, max_live <= LAT + 1}, 32'h1);
        check("ten_live_done", $countones(dut.vld_q) + int'(dut.h_v_q), 0);
        take_out();

        // Gapped operands force recirculation of lone partial sums.
        send(32'h3F800000, 1'b0);
        tick(3);
        send(32'h40000000, 1'b0);
        tick(5);
        send(32'h40400000, 1'b0);
        tick(7);
        send(32'hC0000000, 1'b1);
        wait_out(cyc);
        check("gap_data", out_data, 32'h40800000);
        take_out();

        // Consumer stalls; input attempts must be ignored.
        send(32'h40A00000, 1'b1);
        wait_out(cyc);
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        for (int i = 0; i < 20; i++) begin
            check("hold_data", out_data, 32'h40A00000);
            tick(1);
        end
        check("hold_valid", {31'h0, out_valid}, 32'h1);
        check("hold_in_ready", {31'h0, in_ready}, 32'h0);
        in_valid = 1'b0;
        take_out();
        send(32'h40000000, 1'b1);
        wait_out(cyc);
        check("after_hold_data", out_data, 32'h40000000);
        take_out();

        // Reset in the middle of a reduction.
        hs0 = n_hs;
        for (int i = 0; i < 10; i++) send(32'h3F800000, i == 9);
        tick(LAT + 3);
        check("mid_busy", {31'h0, busy}, 32'h1);
        #2;
        RESETn = 1'b0;
        #1;
        check("mid_rst_add_A", add_A, 32'h0);
        check("mid_rst_add_B", add_B, 32'h0);
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_data", out_data, 32'h0);
        tick(2);
        RESETn = 1'b1;
        tick(1);
        check("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
        tick(3 * LAT);
        check("mid_no_stale_out", n_hs - hs0, 0);
        send(32'h3F800000, 1'b0);
        send(32'h3F800000, 1'b1);
        wait_out(cyc);
        check("post_rst_data", out_data, 32'h40000000);
        take_out();
        check("post_rst_one_pulse", n_hs - hs0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
